pwm_deadtime: RTL and testbench

PWM_DEADTIME -- requirements
Module: pwm_deadtime

---
 rtl/pwm_deadtime.sv | 162 ++++++++++++++++
 tb/tb_pwm_deadtime.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// Complementary PWM gate driver with programmable rising/falling dead time,
// synchronised brake input and a small register bank (CTRL, STAT, CNT).
module pwm_deadtime #(
   parameter int DT_W = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  waddr_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  sel_i,
   input  logic        we_i,
   input  logic [7:0]  raddr_i,
   input  logic        rd_i,
   output logic [31:0] data_o,
   input  logic        pwm_i,
   input  logic        brake_i,
   output logic        pwm_hi_o,
   output logic        pwm_lo_o,
   output logic        irq_brake_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LO_ON   = 3'd1,
      DEAD_LH = 3'd2,
      HI_ON   = 3'd3,
      DEAD_HL = 3'd4,
      BRAKE   = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [DT_W-1:0] cnt_q, cnt_d;
   logic [DT_W-1:0] dt_r_q, dt_f_q;
   logic            en_q, inv_q, brk_en_q, brk_lvl_q;
   logic            brk_flag_q, brk_flag_d;
   logic            brk_m_q, brk_s_q, pwm_q;
   logic            hi_q, lo_q, irq_q;
   logic [31:0]     data_q, data_d;
   logic            ctrl_we, stat_w1c, brake_act, rise, fall;
   logic            unused_bits;

   // Bus: a write with we_i=1 lands on the next edge; a read with rd_i=1
   // presents its data on data_o from the next edge until the next read.
   assign ctrl_we     = we_i && (waddr_i == 8'h00);
   assign stat_w1c    = we_i && (waddr_i == 8'h04) && data_i[0];
   assign brake_act   = brk_en_q && (brk_s_q == brk_lvl_q);
   assign rise        = pwm_i && !pwm_q;
   assign fall        = !pwm_i && pwm_q;
   assign unused_bits = ^{sel_i, data_i[31:24], data_i[7:4]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (brake_act) begin
         state_d = BRAKE;
         cnt_d   = '0;
      end else if (state_q == BRAKE) begin
         if (!brk_flag_q) begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      end else if (!en_q) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE, LO_ON, HI_ON: begin
               // IDLE starts towards whichever side pwm_i currently asks for
               if ((state_q == IDLE && pwm_i) || (state_q == LO_ON && rise)) begin
                  if (dt_r_q == '0) state_d = HI_ON;
                  else begin
                     state_d = DEAD_LH;
                     cnt_d   = dt_r_q - DT_W'(1);
                  end
               end else if ((state_q == IDLE && !pwm_i) || (state_q == HI_ON && fall)) begin
                  if (dt_f_q == '0) state_d = LO_ON;
                  else begin
                     state_d = DEAD_HL;
                     cnt_d   = dt_f_q - DT_W'(1);
                  end
               end
            end
            DEAD_LH: begin
               if (!pwm_i)             state_d = LO_ON;
               else if (cnt_q == '0)   state_d = HI_ON;
               else                    cnt_d   = cnt_q - DT_W'(1);
            end
            DEAD_HL: begin
               if (pwm_i)              state_d = HI_ON;
               else if (cnt_q == '0)   state_d = LO_ON;
               else                    cnt_d   = cnt_q - DT_W'(1);
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      brk_flag_d = brk_flag_q;
      if (brake_act)     brk_flag_d = 1'b1;
      else if (stat_w1c) brk_flag_d = 1'b0;
   end

   always_comb begin
      data_d = data_q;
      if (rd_i) begin
         unique case (raddr_i)
            8'h00:   data_d = {8'd0, dt_f_q, dt_r_q, 4'd0, brk_lvl_q, brk_en_q, inv_q, en_q};
            8'h04:   data_d = {27'd0, brk_s_q, state_q, brk_flag_q};
            8'h08:   data_d = 32'(cnt_q);
            default: data_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         en_q       <= 1'b0;
         inv_q      <= 1'b0;
         brk_en_q   <= 1'b0;
         brk_lvl_q  <= 1'b0;
         dt_r_q     <= '0;
         dt_f_q     <= '0;
         brk_flag_q <= 1'b0;
         brk_m_q    <= 1'b0;
         brk_s_q    <= 1'b0;
         pwm_q      <= 1'b0;
         hi_q       <= 1'b0;
         lo_q       <= 1'b0;
         irq_q      <= 1'b0;
         data_q     <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         brk_flag_q <= brk_flag_d;
         brk_m_q    <= brake_i;
         brk_s_q    <= brk_m_q;
         pwm_q      <= pwm_i;
         // Gate drives follow the state being entered, so they never lag it
         hi_q       <= (state_d == HI_ON) ^ inv_q;
         lo_q       <= (state_d == LO_ON) ^ inv_q;
         irq_q      <= brake_act && (state_q != BRAKE);
         data_q     <= data_d;
         if (ctrl_we) begin
            en_q      <= data_i[0];
            inv_q     <= data_i[1];
            brk_en_q  <= data_i[2];
            brk_lvl_q <= data_i[3];
            dt_r_q    <= data_i[8 +: DT_W];
            dt_f_q    <= data_i[16 +: DT_W];
         end
      end
   end

   assign pwm_hi_o    = hi_q;
   assign pwm_lo_o    = lo_q;
   assign irq_brake_o = irq_q;
   assign data_o      = data_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: directed sequences with literal expectations plus a
// behavioural model of the gate-drive rules compared against the DUT every cycle.
module tb_pwm_deadtime;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  waddr_i = 8'h00;
   logic [31:0] data_i = 32'h0;
   logic [3:0]  sel_i = 4'h0;
   logic        we_i = 1'b0;
   logic [7:0]  raddr_i = 8'h00;
   logic        rd_i = 1'b0;
   logic [31:0] data_o;
   logic        pwm_i = 1'b0;
   logic        brake_i = 1'b0;
   logic        pwm_hi_o, pwm_lo_o, irq_brake_o;

   int tests = 0;
   int fails = 0;

   pwm_deadtime #(.DT_W(8)) dut (
      .clk(clk), .rst(rst),
      .waddr_i(waddr_i), .data_i(data_i), .sel_i(sel_i), .we_i(we_i),
      .raddr_i(raddr_i), .rd_i(rd_i), .data_o(data_o),
      .pwm_i(pwm_i), .brake_i(brake_i),
      .pwm_hi_o(pwm_hi_o), .pwm_lo_o(pwm_lo_o), .irq_brake_o(irq_brake_o)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 running, 2 braked. on: 0 none (dead), 1 low side, 2 high side.
   // tgt: side being headed for while dead. m_wait: dead cycles left incl. current.
   int          m_mode = 0, m_on = 0, m_tgt = 1, m_wait = 0;
   logic        m_en = 0, m_inv = 0, m_brk_en = 0, m_brk_lvl = 0, m_flag = 0;
   logic        m_s1 = 0, m_s2 = 0, m_prev = 0;
   logic [7:0]  m_dtr = 0, m_dtf = 0;
   logic        exp_hi = 0, exp_lo = 0, exp_irq = 0, m_out_inv = 0;
   logic [31:0] exp_data = 0;
   logic        data_known = 1;

   task automatic model_reset();
      m_mode = 0; m_on = 0; m_tgt = 1; m_wait = 0;
      m_en = 0; m_inv = 0; m_brk_en = 0; m_brk_lvl = 0; m_flag = 0;
      m_s1 = 0; m_s2 = 0; m_prev = 0; m_dtr = 0; m_dtf = 0;
      exp_hi = 0; exp_lo = 0; exp_irq = 0; m_out_inv = 0;
      exp_data = 0; data_known = 1;
   endtask

   task automatic model_step();
      logic brk, go, goto;
      int   mode_n, on_n, tgt_n, wait_n, code;
      go   = 0;
      goto = 0;
      brk  = m_brk_en && (m_s2 == m_brk_lvl);
      code = (m_mode == 0) ? 0 : (m_mode == 2) ? 5 : (m_on == 1) ? 1 :
             (m_on == 2) ? 3 : (m_tgt == 2) ? 2 : 4;
      if (rd_i) begin
         data_known = 1;
         case (raddr_i)
            8'h00: exp_data = {8'h00, m_dtf, m_dtr, 4'h0, m_brk_lvl, m_brk_en, m_inv, m_en};
            8'h04: exp_data = {27'd0, m_s2, code[2:0], m_flag};
            8'h08: if (code == 2 || code == 4) exp_data = 32'(m_wait - 1);
                   else data_known = 0;
            default: exp_data = 32'd0;
         endcase
      end
      mode_n = m_mode; on_n = m_on; tgt_n = m_tgt; wait_n = m_wait;
      if (brk) mode_n = 2;
      else if (m_mode == 2) begin
         if (!m_flag) mode_n = 0;
      end else if (!m_en) mode_n = 0;
      else if (m_mode == 0) begin
         mode_n = 1; go = 1; goto = pwm_i;
      end else if (m_on == 0) begin
         if (pwm_i != (m_tgt == 2)) on_n = pwm_i ? 2 : 1;
         else if (m_wait == 1)      on_n = m_tgt;
         else                       wait_n = m_wait - 1;
      end else if (m_on == 1 && pwm_i && !m_prev) begin
         go = 1; goto = 1;
      end else if (m_on == 2 && !pwm_i && m_prev) begin
         go = 1; goto = 0;
      end
      if (go) begin
         tgt_n  = goto ? 2 : 1;
         wait_n = goto ? int'(m_dtr) : int'(m_dtf);
         on_n   = (wait_n == 0) ? tgt_n : 0;
      end
      exp_irq   = brk && (m_mode != 2);
      exp_hi    = (mode_n == 1 && on_n == 2) ^ m_inv;
      exp_lo    = (mode_n == 1 && on_n == 1) ^ m_inv;
      m_out_inv = m_inv;
      if (brk) m_flag = 1;
      else if (we_i && waddr_i == 8'h04 && data_i[0]) m_flag = 0;
      m_mode = mode_n; m_on = on_n; m_tgt = tgt_n; m_wait = wait_n;
      m_s2 = m_s1; m_s1 = brake_i; m_prev = pwm_i;
      if (we_i && waddr_i == 8'h00) begin
         m_en = data_i[0]; m_inv = data_i[1]; m_brk_en = data_i[2]; m_brk_lvl = data_i[3];
         m_dtr = data_i[15:8]; m_dtf = data_i[23:16];
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
   end

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string name, input logic hi, input logic lo);
      chk({name, "_hi"}, 32'(pwm_hi_o), 32'(hi));
      chk({name, "_lo"}, 32'(pwm_lo_o), 32'(lo));
      chk({name, "_model_hi"}, 32'(exp_hi), 32'(hi));
      chk({name, "_model_lo"}, 32'(exp_lo), 32'(lo));
   endtask

   logic chk_on = 0, chk_dt = 0;
   int   cur_dtr = 0, cur_dtf = 0;
   int   hi_gap = 1000, lo_gap = 1000;
   logic hi_prev = 0, lo_prev = 0;

   initial forever begin
      logic hi_act, lo_act;
      @(negedge clk);
      if (!rst && chk_on) begin
         chk("cyc_hi", 32'(pwm_hi_o), 32'(exp_hi));
         chk("cyc_lo", 32'(pwm_lo_o), 32'(exp_lo));
         chk("cyc_irq", 32'(irq_brake_o), 32'(exp_irq));
         if (data_known) chk("cyc_data", data_o, exp_data);
         hi_act = (pwm_hi_o != m_out_inv);
         lo_act = (pwm_lo_o != m_out_inv);
         chk("overlap", 32'(hi_act && lo_act), 32'd0);
         if (chk_dt && hi_act && !hi_prev) chk("dead_lh_short", 32'(lo_gap >= cur_dtr), 32'd1);
         if (chk_dt && lo_act && !lo_prev) chk("dead_hl_short", 32'(hi_gap >= cur_dtf), 32'd1);
         hi_gap  = hi_act ? 0 : hi_gap + 1;
         lo_gap  = lo_act ? 0 : lo_gap + 1;
         hi_prev = hi_act;
         lo_prev = lo_act;
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      we_i = 1'b1; waddr_i = a; data_i = d;
      tick();
      we_i = 1'b0; data_i = 32'h0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] v);
      rd_i = 1'b1; raddr_i = a;
      tick();
      rd_i = 1'b0;
      v = data_o;
   endtask

   // ---------------- directed sequences ----------------
   initial begin
      logic [31:0] v;
      logic [7:0]  dtr_v, dtf_v;
      repeat (3) tick();
      chk_out("reset", 1'b0, 1'b0);
      chk("reset_irq", 32'(irq_brake_o), 32'd0);
      chk("reset_data", data_o, 32'd0);
      rst = 1'b0;
      chk_on = 1'b1;
      tick();

      // dt_r=3, dt_f=0: low side on at once, rise gives 3 dead cycles
      wr(8'h00, 32'h0000_0301);
      tick(); tick();
      chk_out("lo_start", 1'b0, 1'b1);
      pwm_i = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk_out($sformatf("rise_n%0d", i), (i == 4), 1'b0);
      end
      rd(8'h00, v);
      chk("ctrl_rb", v, 32'h0000_0301);

      // dt_f=5: fall then early re-rise returns to high side, low side untouched
      wr(8'h00, 32'h0005_0301);
      pwm_i = 1'b0;
      tick(); chk_out("fall_d1", 1'b0, 1'b0);
      tick(); chk_out("fall_d2", 1'b0, 1'b0);
      pwm_i = 1'b1;
      tick(); chk_out("rerise", 1'b1, 1'b0);

      // full falling dead time, then a short pulse that is swallowed
      pwm_i = 1'b0;
      repeat (6) tick();
      chk_out("fall_full", 1'b0, 1'b1);
      pwm_i = 1'b1;
      tick(); chk_out("swallow_a", 1'b0, 1'b0);
      tick(); chk_out("swallow_b", 1'b0, 1'b0);
      pwm_i = 1'b0;
      tick(); chk_out("swallow_c", 1'b0, 1'b1);

      // brake active high
      wr(8'h00, 32'h0005_030D);
      brake_i = 1'b1;
      tick(); chk_out("brk_1", 1'b0, 1'b1); chk("brk_irq1", 32'(irq_brake_o), 32'd0);
      tick(); chk_out("brk_2", 1'b0, 1'b1); chk("brk_irq2", 32'(irq_brake_o), 32'd0);
      tick(); chk_out("brk_3", 1'b0, 1'b0); chk("brk_irq3", 32'(irq_brake_o), 32'd1);
      tick(); chk_out("brk_4", 1'b0, 1'b0); chk("brk_irq4", 32'(irq_brake_o), 32'd0);
      rd(8'h04, v);
      chk("stat_brake", v, 32'h0000_001B);
      wr(8'h04, 32'h1);
      rd(8'h04, v);
      chk("stat_w1c_lost", v, 32'h0000_001B);

      // release, clear flag, restart with full falling dead time
      brake_i = 1'b0;
      repeat (3) tick();
      wr(8'h04, 32'h1);
      tick(); chk_out("rel_idle", 1'b0, 1'b0);
      rd(8'h04, v);
      chk("stat_idle", v, 32'h0);
      rd(8'h08, v);
      chk("cnt_load", v, 32'd4);
      chk_out("rel_d2", 1'b0, 1'b0);
      for (int i = 3; i <= 5; i++) begin
         tick();
         chk_out($sformatf("rel_d%0d", i), 1'b0, 1'b0);
      end
      tick(); chk_out("rel_on", 1'b0, 1'b1);

      // inverted polarity, disabled
      wr(8'h00, 32'h0000_0002);
      tick(); chk_out("inv_idle", 1'b1, 1'b1);
      rd(8'h04, v);  chk("inv_stat", v, 32'h0);
      rd(8'h0C, v);  chk("unmapped", v, 32'h0);
      rd(8'h00, v);  chk("inv_ctrl", v, 32'h0000_0002);
      raddr_i = 8'h04;
      tick();
      chk("rd_hold", data_o, 32'h0000_0002);

      // random pwm against random dead times
      for (int c = 0; c < 4; c++) begin
         wr(8'h00, 32'h0);
         tick(); tick();
         cur_dtr = $urandom_range(0, 6);
         cur_dtf = $urandom_range(0, 6);
         dtr_v = 8'(cur_dtr);
         dtf_v = 8'(cur_dtf);
         wr(8'h00, {8'h00, dtf_v, dtr_v, 8'h01});
         chk_dt = 1'b1;
         for (int k = 0; k < 50; k++) begin
            pwm_i = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 9)) tick();
            if (k == 25) begin
               rd(8'h08, v);
               rd(8'h04, v);
            end
         end
         chk_dt = 1'b0;
      end

      // asynchronous reset mid-operation
      wr(8'h00, 32'h0);
      tick();
      pwm_i = 1'b1;
      wr(8'h00, 32'h0005_0301);
      repeat (4) tick();
      chk_out("pre_rst", 1'b1, 1'b0);
      #3 rst = 1'b1;
      #1 chk_out("async_rst", 1'b0, 1'b0);
      chk("async_rst_data", data_o, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();
      chk_out("post_rst", 1'b0, 1'b0);
      rd(8'h04, v);  chk("post_rst_stat", v, 32'h0);
      rd(8'h00, v);  chk("post_rst_ctrl", v, 32'h0);
      tick();
      chk_out("post_rst_idle", 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
